// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage access controller: opcodes, FSM states,
// access-size decode and byte-lane helpers.
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  typedef enum logic [1:0] {SZ_NONE, SZ_B, SZ_H, SZ_W} size_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic size_t access_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_B;
      OP_LH, OP_LHU, OP_SH: return SZ_H;
      OP_LW, OP_SW:         return SZ_W;
      default:              return SZ_NONE;
    endcase
  endfunction

  function automatic logic misaligned(input size_t sz, input logic [1:0] a);
    case (sz)
      SZ_H:    return a[0];
      SZ_W:    return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] byte_enables(input size_t sz, input logic [1:0] a);
    case (sz)
      SZ_B:    return BE_W'(1) << a;
      SZ_H:    return a[1] ? 4'b1100 : 4'b0011;
      SZ_W:    return 4'b1111;
      default: return '0;
    endcase
  endfunction

  // Replicate the narrow store value across every lane so the RAM only needs byte enables.
  function automatic logic [31:0] lane_wdata(input size_t sz, input logic [31:0] wd);
    case (sz)
      SZ_B:    return {4{wd[7:0]}};
      SZ_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Load-data lane select with sign/zero extension; purely combinational so it
// can also be reused by WB forwarding.
module load_extract
  import mips_mem_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    data = word;
    case (opcode)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'd0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: byte-lane request generation, req/ack
// handshake with pipeline stall, and load extraction. Optional macro MEM_TIMEOUT_EN.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
)(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [5:0]        i_opcode,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic              o_req,
  output logic              o_we,
  output logic [BE_W-1:0]   o_be,
  output logic [ADDR_W-1:0] o_maddr,
  output logic [31:0]       o_mwdata,
  input  logic              i_ack,
  input  logic [31:0]       i_mrdata,
  output logic [31:0]       o_rdata,
  output logic              o_rvalid,
  output logic              o_done,
`ifdef MEM_TIMEOUT_EN
  output logic              o_bus_err,
`endif
  output logic              o_misalign
);

  state_t      state;
  logic [5:0]  op_q;
  logic [1:0]  addr_lo_q;
  size_t       sz;
  logic        is_mem;
  logic        bad_align;
  logic        accept;
  logic [31:0] ext_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  assign sz        = access_size(i_opcode);
  assign is_mem    = i_valid && (is_load(i_opcode) || is_store(i_opcode));
  assign bad_align = misaligned(sz, i_addr[1:0]);
  assign accept    = i_reset_n && (state == IDLE) && is_mem && !bad_align;

  // Stall is combinational so EX/MEM freezes in the very cycle the access is accepted.
  assign o_stall = accept || (state == REQ);

  load_extract u_extract (
    .opcode  (op_q),
    .addr_lo (addr_lo_q),
    .word    (i_mrdata),
    .data    (ext_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      op_q       <= '0;
      addr_lo_q  <= '0;
      o_req      <= 1'b0;
      o_we       <= 1'b0;
      o_be       <= '0;
      o_maddr    <= '0;
      o_mwdata   <= '0;
      o_rdata    <= '0;
      o_rvalid   <= 1'b0;
      o_done     <= 1'b0;
      o_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      o_bus_err  <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      o_rvalid   <= 1'b0;
      o_done     <= 1'b0;
      o_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      o_bus_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= i_opcode;
            addr_lo_q <= i_addr[1:0];
            o_we      <= is_store(i_opcode);
            o_be      <= byte_enables(sz, i_addr[1:0]);
            o_maddr   <= {i_addr[ADDR_W-1:2], 2'b00};
            o_mwdata  <= lane_wdata(sz, i_wdata);
            o_req     <= 1'b1;
            state     <= REQ;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end else if (is_mem && bad_align) begin
            o_misalign <= 1'b1;
          end
        end
        REQ: begin
          // Completion pulses are set here so they are visible during the DONE cycle.
          if (i_ack) begin
            if (!o_we) o_rdata <= ext_data;
            o_rvalid <= !o_we;
            o_done   <= 1'b1;
            o_req    <= 1'b0;
            state    <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            o_req     <= 1'b0;
            o_bus_err <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl plus hand-written sequences
// for ack ordering, back-to-back accesses and reset mid-request.
module tb_mem_access_ctrl;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_valid;
  logic [5:0]  i_opcode;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic        o_req;
  logic        o_we;
  logic [3:0]  o_be;
  logic [31:0] o_maddr;
  logic [31:0] o_mwdata;
  logic        i_ack;
  logic [31:0] i_mrdata;
  logic [31:0] o_rdata;
  logic        o_rvalid;
  logic        o_done;
  logic        o_misalign;
`ifdef MEM_TIMEOUT_EN
  logic        o_bus_err;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  mem_access_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_valid    (i_valid),
    .i_opcode   (i_opcode),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_stall    (o_stall),
    .o_req      (o_req),
    .o_we       (o_we),
    .o_be       (o_be),
    .o_maddr    (o_maddr),
    .o_mwdata   (o_mwdata),
    .i_ack      (i_ack),
    .i_mrdata   (i_mrdata),
    .o_rdata    (o_rdata),
    .o_rvalid   (o_rvalid),
    .o_done     (o_done),
`ifdef MEM_TIMEOUT_EN
    .o_bus_err  (o_bus_err),
`endif
    .o_misalign (o_misalign)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          ack_delay;
    bit          misalign;
    logic [3:0]  be;
    logic [31:0] mwdata;
    bit          store;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [5:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] mrdata,
                              input int ack_delay, input bit misalign,
                              input logic [3:0] be, input logic [31:0] mwdata,
                              input bit store, input logic [31:0] rdata);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.mrdata = mrdata;
    v.ack_delay = ack_delay; v.misalign = misalign; v.be = be;
    v.mwdata = mwdata; v.store = store; v.rdata = rdata;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one vector from acceptance to retirement; sampling is at mid-cycle.
  task automatic applyStimulus(input vec_t v);
    int  stalls;
    int  cyc;
    bit  done_seen;
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_opcode = v.op; i_addr = v.addr; i_wdata = v.wdata;
    i_mrdata = v.mrdata; i_ack = 1'b0;
    #4;
    stalls = int'(o_stall);
    if (v.misalign) begin
      checkOutput("misalign_stall0", o_stall, 0);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      #4;
      checkOutput("misalign_pulse", o_misalign, 1);
      checkOutput("misalign_req", o_req, 0);
      checkOutput("misalign_stall1", o_stall, 0);
      @(posedge i_clk); #5;
      checkOutput("misalign_clear", o_misalign, 0);
      checkOutput("misalign_req2", o_req, 0);
      return;
    end
    done_seen = 1'b0;
    cyc = 0;
    while (!done_seen && cyc < 20) begin
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      cyc++;
      i_ack = (cyc == v.ack_delay);
      #4;
      if (o_done === 1'b1) begin
        done_seen = 1'b1;
        checkOutput("done_stall", o_stall, 0);
        checkOutput("done_req", o_req, 0);
        checkOutput("done_rvalid", o_rvalid, v.store ? 32'd0 : 32'd1);
        if (!v.store) checkOutput("load_rdata", o_rdata, v.rdata);
      end else begin
        stalls += int'(o_stall);
        checkOutput("req_high", o_req, 1);
        checkOutput("req_we", o_we, v.store ? 32'd1 : 32'd0);
        checkOutput("req_be", o_be, v.be);
        checkOutput("req_maddr", o_maddr, {v.addr[31:2], 2'b00});
        if (v.store) checkOutput("req_mwdata", o_mwdata, v.mwdata);
      end
    end
    i_ack = 1'b0;
    checkOutput("done_seen", done_seen, 1);
    checkOutput("stall_cycles", stalls, 1 + v.ack_delay);
    @(posedge i_clk); #5;
    checkOutput("done_pulse_end", o_done, 0);
    checkOutput("rvalid_pulse_end", o_rvalid, 0);
  endtask

  initial begin
    vecs[0]  = mk(SB,  32'h103, 32'h000000A5, 32'h0,        2, 0, 4'b1000, 32'hA5A5A5A5, 1, 32'h0);
    vecs[1]  = mk(LB,  32'h202, 32'h0,        32'h12F45678, 1, 0, 4'b0100, 32'h0,        0, 32'hFFFFFFF4);
    vecs[2]  = mk(LBU, 32'h202, 32'h0,        32'h12F45678, 1, 0, 4'b0100, 32'h0,        0, 32'h000000F4);
    vecs[3]  = mk(LHU, 32'h202, 32'h0,        32'h12F45678, 2, 0, 4'b1100, 32'h0,        0, 32'h000012F4);
    vecs[4]  = mk(LH,  32'h200, 32'h0,        32'h12F45678, 1, 0, 4'b0011, 32'h0,        0, 32'h00005678);
    vecs[5]  = mk(LW,  32'h302, 32'h0,        32'h0,        1, 1, 4'b0000, 32'h0,        0, 32'h0);
    vecs[6]  = mk(SH,  32'h301, 32'h0000BEEF, 32'h0,        1, 1, 4'b0000, 32'h0,        1, 32'h0);
    vecs[7]  = mk(LH,  32'h206, 32'h0,        32'h80010000, 3, 0, 4'b1100, 32'h0,        0, 32'hFFFF8001);
    vecs[8]  = mk(SH,  32'h102, 32'h0000BEEF, 32'h0,        1, 0, 4'b1100, 32'hBEEFBEEF, 1, 32'h0);
    vecs[9]  = mk(LW,  32'h400, 32'h0,        32'hDEADBEEF, 1, 0, 4'b1111, 32'h0,        0, 32'hDEADBEEF);
    vecs[10] = mk(LB,  32'h001, 32'h0,        32'h00007F00, 2, 0, 4'b0010, 32'h0,        0, 32'h0000007F);
    vecs[11] = mk(SW,  32'h010, 32'h12345678, 32'h0,        1, 0, 4'b1111, 32'h12345678, 1, 32'h0);

    i_reset_n = 1'b0; i_valid = 1'b0; i_opcode = '0; i_addr = '0;
    i_wdata = '0; i_ack = 1'b0; i_mrdata = '0;
    repeat (3) @(posedge i_clk);
    #5;
    checkOutput("rst_req", o_req, 0);
    checkOutput("rst_stall", o_stall, 0);
    checkOutput("rst_be", o_be, 0);
    checkOutput("rst_rdata", o_rdata, 0);
    checkOutput("rst_done", o_done, 0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;

    for (int k = 0; k < 12; k++) applyStimulus(vecs[k]);

    // Non-memory opcode with valid: no stall, no request.
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_opcode = 6'b000000; i_addr = 32'h123;
    #4;
    checkOutput("alu_stall", o_stall, 0);
    @(posedge i_clk); #5;
    checkOutput("alu_req", o_req, 0);
    checkOutput("alu_misalign", o_misalign, 0);

    // Ack held high in IDLE and through acceptance must not short-circuit REQ.
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_ack = 1'b1; i_mrdata = 32'hCAFEF00D;
    #4;
    checkOutput("spur_done", o_done, 0);
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_opcode = LW; i_addr = 32'h500;
    #4;
    checkOutput("spur_accept_stall", o_stall, 1);
    checkOutput("spur_accept_done", o_done, 0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    #4;
    checkOutput("spur_req", o_req, 1);
    checkOutput("spur_req_done", o_done, 0);
    @(posedge i_clk); #1;
    i_ack = 1'b0;
    #4;
    checkOutput("spur_done_pulse", o_done, 1);
    checkOutput("spur_rdata", o_rdata, 32'hCAFEF00D);

    // Back-to-back stores: the second is held off by DONE, giving one bubble.
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_opcode = SW; i_addr = 32'h600; i_wdata = 32'hAAAA5555; i_ack = 1'b1;
    #4;
    checkOutput("b2b_acc1_stall", o_stall, 1);
    @(posedge i_clk); #5;
    checkOutput("b2b_req1", o_req, 1);
    checkOutput("b2b_mwdata1", o_mwdata, 32'hAAAA5555);
    @(posedge i_clk); #5;
    checkOutput("b2b_done1", o_done, 1);
    checkOutput("b2b_bubble_stall", o_stall, 0);
    checkOutput("b2b_bubble_req", o_req, 0);
    @(posedge i_clk); #1;
    i_addr = 32'h604; i_wdata = 32'h00000011;
    #4;
    checkOutput("b2b_acc2_stall", o_stall, 1);
    checkOutput("b2b_acc2_req", o_req, 0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    #4;
    checkOutput("b2b_req2", o_req, 1);
    checkOutput("b2b_maddr2", o_maddr, 32'h604);
    checkOutput("b2b_mwdata2", o_mwdata, 32'h00000011);
    @(posedge i_clk); #1;
    i_ack = 1'b0;
    #4;
    checkOutput("b2b_done2", o_done, 1);

    // Reset while a request is outstanding.
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_opcode = LW; i_addr = 32'h700;
    #4;
    checkOutput("rreq_accept", o_stall, 1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    #4;
    checkOutput("rreq_req", o_req, 1);
    @(posedge i_clk); #1;
    i_reset_n = 1'b0;
    @(posedge i_clk); #5;
    checkOutput("rreq_req_after", o_req, 0);
    checkOutput("rreq_stall_after", o_stall, 0);
    checkOutput("rreq_we_after", o_we, 0);
    checkOutput("rreq_be_after", o_be, 0);
    checkOutput("rreq_maddr_after", o_maddr, 0);
    checkOutput("rreq_mwdata_after", o_mwdata, 0);
    checkOutput("rreq_rdata_after", o_rdata, 0);
    checkOutput("rreq_done_after", o_done, 0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    applyStimulus(mk(LW, 32'h800, 32'h0, 32'h0BADF00D, 1, 0, 4'b1111, 32'h0, 0, 32'h0BADF00D));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
MEM-stage data-memory access controller. It sits directly downstream of the store-data width detector (sb/sh/sw zero-extension) and between the EX/MEM pipeline register and the data RAM.
- Converts the load/store opcode plus address into a byte-lane request (byte enables, lane-replicated write data).
- Runs a req/ack handshake with a variable-latency data memory and stalls the pipeline until the access completes.
- Returns load data sign- or zero-extended to 32 bits for the MEM/WB register.

Parameters:
ADDR_W, 32, byte-address width presented to memory
TIMEOUT_CYC, 16, max cycles waiting for ack (used only with MEM_TIMEOUT_EN)

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  synchronous reset, active low
i_valid  in  1  EX/MEM slot holds a valid instruction
i_opcode  in  6  MIPS opcode of the MEM-stage instruction
i_addr  in  ADDR_W  effective byte address
i_wdata  in  32  store data, already zero-extended by the width detector
o_stall  out  1  freeze IF..EX/MEM while an access is in flight
o_req  out  1  memory request
o_we  out  1  1 = write, 0 = read
o_be  out  4  byte enables, bit n = byte lane n (little-endian)
o_maddr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
o_mwdata  out  32  lane-replicated write data
i_ack  in  1  memory completes the access this cycle
i_mrdata  in  32  read word, valid when i_ack
o_rdata  out  32  extended load result
o_rvalid  out  1  one-cycle pulse: o_rdata valid (loads only)
o_done  out  1  one-cycle pulse: access (load or store) retired
o_misalign  out  1  one-cycle pulse: misaligned access rejected

Behaviour:
- Clock and reset: i_clk only. Reset is synchronous, active low (i_reset_n). Reset is sampled at the rising edge, overrides everything and aborts any in-flight request; memory sees o_req drop at that edge.
- Reset values: all outputs 0; state IDLE.
- Opcodes decoded:
  - Loads: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101.
  - Stores: sb 101000, sh 101001, sw 101011.
  - Anything else, or i_valid=0: no access, no stall.
- Alignment rules:
  - h-type: addr[0] must be 0.
  - w-type: addr[1:0] must be 00.
  - On violation in IDLE: o_misalign pulses the next cycle, no req, no stall.
- Byte enables:
  - b-type: be = 1<<addr[1:0].
  - h-type: be = addr[1] ? 1100 : 0011.
  - w-type: be = 1111.
- Write data: sb {4{wdata[7:0]}}, sh {2{wdata[15:0]}}, sw wdata.
- FSM states: IDLE, REQ, DONE.
  - IDLE: on a valid, aligned load or store, register opcode, addr[1:0], be, address and wdata, then go to REQ. o_stall is asserted combinationally in this same cycle so EX/MEM holds.
  - REQ: o_req=1. o_we, o_be, o_maddr and o_mwdata stay stable until ack. o_stall=1. i_ack is sampled only while o_req=1; ack while o_req=0 is ignored. On i_ack:
    - Load: capture the extracted lane into o_rdata.
    - Then go to DONE; o_req drops at the same edge.
  - DONE: o_done=1 and o_stall=0 for one cycle; o_rvalid=1 for loads; then IDLE. A new access presented in DONE is not accepted until IDLE, so back-to-back accesses have a 1-cycle bubble.
- Minimum latency: accept in cycle 0, req high in cycle 1, ack in cycle 1, result in cycle 2 (3 cycles total).
- Load extraction by addr[1:0]:
  - lb/lbu: byte lane, sign- or zero-extended.
  - lh/lhu: lane addr[1].
  - lw: full word.
- o_rdata holds its value until the next load completes.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a counter starts at entry to REQ. If TIMEOUT_CYC cycles pass with no ack, the FSM drops o_req, pulses o_bus_err (extra 1-bit output port, present only with the macro) and goes to IDLE with o_stall low; o_done is not asserted.
- Undefined: no port and no counter; REQ waits indefinitely.

Decomposition:
- Shared package/header (mips_mem_pkg):
  - Opcode localparams (OP_LB..OP_SW).
  - FSM state encodings (IDLE/REQ/DONE).
  - Width constant for the byte-enable vector.
- One sub-module, load_extract: combinational lane select plus sign/zero extension (opcode, addr[1:0], word -> 32b). Reusable by WB forwarding.

Test Plan:
- sb addr 0x103, wdata 0x000000A5, ack after 2 cycles -> o_be=1000, o_mwdata=A5A5A5A5, o_maddr=0x100, o_stall high for 3 cycles, o_done pulse, o_rvalid=0.
- lb addr 0x202, i_mrdata 0x12F45678 -> o_rdata=0xFFFFFFF4. lbu same -> 0x000000F4. lhu addr 0x202 -> 0x000012F4. lh addr 0x200 -> 0x00005678.
- lw addr 0x302 -> o_misalign pulse, o_req never asserted, o_stall 0. sh addr 0x301 -> same result.
- Spurious i_ack in IDLE, plus ack in the first REQ cycle -> spurious ack ignored; access completes with minimum 3-cycle latency; back-to-back sw, sw -> 1-cycle bubble between them.
- Reset asserted during REQ -> o_req, o_stall and all outputs 0 after the edge; a later lw completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYC=4, ack withheld -> o_bus_err pulse after 4 REQ cycles, FSM back to IDLE, no o_done.
